// File: rtl/spi_adc_sequencer.sv
// Round-robin SPI ADC scanner (mode 0). It sends the channel address on MOSI and
// shifts in the conversion on MISO. The address sent in one frame selects the result
// returned in the next frame, so each sample is tagged with the previous frame's address.
module spi_adc_sequencer #(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned ADDR_BITS    = $clog2(NUM_CHANNELS),
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned LEAD_BITS    = 4,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned CS_GAP       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] channel_mask,
  output logic                    spi_cs_n,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic [DATA_BITS-1:0]    sample_data,
  output logic [ADDR_BITS-1:0]    sample_channel,
  output logic                    sample_valid,
  output logic                    busy
);

  localparam int unsigned FrameBits = LEAD_BITS + DATA_BITS;
  localparam int unsigned PhaseMax  = 2 * CLK_DIV - 1;
  localparam int unsigned CntTop    = (2 * CLK_DIV > CS_GAP) ? 2 * CLK_DIV : CS_GAP;
  localparam int unsigned CntW      = $clog2(CntTop + 1);
  localparam int unsigned BitW      = $clog2(FrameBits + 1);

  typedef enum logic [1:0] {StIdle, StCsSetup, StShift, StGap} state_e;

  state_e                stateQ, stateD;
  logic [CntW-1:0]       cntQ, cntD;
  logic [BitW-1:0]       bitQ, bitD;
  logic [ADDR_BITS-1:0]  addrQ, addrD, prevAddrQ, prevAddrD;
  logic                  dummyQ, dummyD;
  logic [DATA_BITS-1:0]  shiftQ, shiftD;
  logic                  csD, sclkD, mosiD, validD, busyD;
  logic [DATA_BITS-1:0]  dataD;
  logic [ADDR_BITS-1:0]  chanD;
  logic [ADDR_BITS-1:0]  addrAligned;
  logic                  scanReq;

  // Next set mask bit strictly after cur, wrapping; returns cur if it is the only one.
  function automatic logic [ADDR_BITS-1:0] nextAddr(input logic [ADDR_BITS-1:0]    cur,
                                                    input logic [NUM_CHANNELS-1:0] mask);
    logic [ADDR_BITS-1:0] idx;
    logic [ADDR_BITS-1:0] res;
    logic                 found;
    res   = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      idx = cur + ADDR_BITS'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign scanReq = enable && (|channel_mask);

  // Next-state logic: frame sequencing, address selection and MISO capture.
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    bitD      = bitQ;
    addrD     = addrQ;
    prevAddrD = prevAddrQ;
    dummyD    = dummyQ;
    shiftD    = shiftQ;
    validD    = 1'b0;
    dataD     = sample_data;
    chanD     = sample_channel;
    unique case (stateQ)
      StIdle: begin
        if (scanReq) begin
          stateD    = StCsSetup;
          cntD      = '0;
          dummyD    = 1'b1;
          prevAddrD = addrQ;
          // Starting just after the top address yields the lowest set bit.
          addrD     = nextAddr(ADDR_BITS'(NUM_CHANNELS - 1), channel_mask);
        end
      end
      StCsSetup: begin
        if (cntQ == CntW'(CLK_DIV - 1)) begin
          stateD = StShift;
          cntD   = '0;
          bitD   = '0;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      StShift: begin
        // Capture on the edge that raises SCLK.
        if (cntQ == CntW'(CLK_DIV - 1)) begin
          shiftD = {shiftQ[DATA_BITS-2:0], spi_miso};
        end
        if (cntQ == CntW'(PhaseMax)) begin
          cntD = '0;
          if (bitQ == BitW'(FrameBits - 1)) begin
            stateD = StGap;
            if (!dummyQ) begin
              validD = 1'b1;
              dataD  = shiftQ;
              chanD  = prevAddrQ;
            end
          end else begin
            bitD = bitQ + 1'b1;
          end
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      StGap: begin
        if (cntQ == CntW'(CS_GAP - 1)) begin
          cntD = '0;
          if (scanReq) begin
            stateD    = StCsSetup;
            dummyD    = 1'b0;
            prevAddrD = addrQ;
            addrD     = nextAddr(addrQ, channel_mask);
          end else begin
            stateD = StIdle;
          end
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Pin values for the upcoming cycle, registered so outputs never see inputs directly.
  always_comb begin
    addrAligned = addrD << bitD;
    csD   = !((stateD == StCsSetup) || (stateD == StShift));
    sclkD = (stateD == StShift) && (cntD >= CntW'(CLK_DIV));
    mosiD = (stateD == StShift) && (bitD < BitW'(ADDR_BITS)) && addrAligned[ADDR_BITS-1];
    busyD = (stateD != StIdle);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ         <= StIdle;
      cntQ           <= '0;
      bitQ           <= '0;
      addrQ          <= '0;
      prevAddrQ      <= '0;
      dummyQ         <= 1'b1;
      shiftQ         <= '0;
      spi_cs_n       <= 1'b1;
      spi_sclk       <= 1'b0;
      spi_mosi       <= 1'b0;
      sample_data    <= '0;
      sample_channel <= '0;
      sample_valid   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      stateQ         <= stateD;
      cntQ           <= cntD;
      bitQ           <= bitD;
      addrQ          <= addrD;
      prevAddrQ      <= prevAddrD;
      dummyQ         <= dummyD;
      shiftQ         <= shiftD;
      spi_cs_n       <= csD;
      spi_sclk       <= sclkD;
      spi_mosi       <= mosiD;
      sample_data    <= dataD;
      sample_channel <= chanD;
      sample_valid   <= validD;
      busy           <= busyD;
    end
  end

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// Bench for spi_adc_sequencer: an ADC model answers on MISO, and a frame-position
// reference model predicts every output on every cycle.
module tb_spi_adc_sequencer;

  localparam int NC = 8;
  localparam int AB = 3;
  localparam int DB = 12;
  localparam int LB = 4;
  localparam int CD = 2;
  localparam int CG = 2;
  localparam int FB = LB + DB;
  localparam int ShiftEnd = CD + 2 * CD * FB;
  localparam int FrameLen = ShiftEnd + CG;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [NC-1:0] channel_mask;
  logic          spi_miso = 1'b0;
  logic          spi_cs_n, spi_sclk, spi_mosi, sample_valid, busy;
  logic [DB-1:0] sample_data;
  logic [AB-1:0] sample_channel;

  spi_adc_sequencer #(
    .NUM_CHANNELS(NC), .DATA_BITS(DB), .LEAD_BITS(LB), .CLK_DIV(CD), .CS_GAP(CG)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .channel_mask(channel_mask),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .sample_data(sample_data), .sample_channel(sample_channel),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Conversion value the ADC returns per channel, and lead-bit style.
  logic [DB-1:0] chanVal [NC];
  bit            leadOnes = 1'b0;

  // Reference model: frame position and scan bookkeeping.
  bit            mActive = 1'b0;
  bit            mDummy  = 1'b0;
  int            mPos = 0, mAddr = 0, mPrevAddr = 0, expChan = 0;
  logic [DB-1:0] mFrameData = '0, expData = '0;

  // ADC model state.
  logic [FB-1:0] adcWord = '0;
  int            adcBit = 0, capAddr = 0, capCnt = 0, pendingAddr = 0, edgeCnt = 0;
  logic          prevCs = 1'b1, prevSclk = 1'b0;

  function automatic int nextCh(input int cur, input logic [NC-1:0] m);
    for (int i = 1; i <= NC; i++) if (m[(cur + i) % NC]) return (cur + i) % NC;
    return cur;
  endfunction

  // Per-cycle monitor: predict, compare, then play the ADC and advance the model.
  always @(negedge clk) begin : monitor
    logic          eCs, eSclk, eMosi, eValid;
    logic [LB-1:0] lead;
    int            sp, bitN;
    if (rst) begin
      mActive = 1'b0; mDummy = 1'b0; mPos = 0; mAddr = 0;
      expData = '0; expChan = 0;
      capCnt = 0; edgeCnt = 0; prevCs = 1'b1; prevSclk = 1'b0; spi_miso = 1'b0;
    end
    eCs = 1'b1; eSclk = 1'b0; eMosi = 1'b0; eValid = 1'b0;
    if (mActive && mPos == 0) mFrameData = chanVal[mPrevAddr];
    if (mActive && mPos < ShiftEnd) eCs = 1'b0;
    if (mActive && mPos >= CD && mPos < ShiftEnd) begin
      sp    = mPos - CD;
      bitN  = sp / (2 * CD);
      eSclk = (sp % (2 * CD)) >= CD;
      if (bitN < AB) eMosi = ((mAddr >> (AB - 1 - bitN)) & 1) != 0;
    end
    if (mActive && mPos == ShiftEnd && !mDummy) begin
      eValid  = 1'b1;
      expData = mFrameData;
      expChan = mPrevAddr;
    end
    checkVal("cs_n", spi_cs_n, eCs);
    checkVal("sclk", spi_sclk, eSclk);
    checkVal("mosi", spi_mosi, eMosi);
    checkVal("busy", busy, mActive);
    checkVal("valid", sample_valid, eValid);
    checkVal("data", sample_data, expData);
    checkVal("channel", sample_channel, expChan);
    if (!rst) begin
      if (prevCs && !spi_cs_n) begin
        lead    = leadOnes ? '1 : LB'($urandom);
        adcWord = {lead, chanVal[pendingAddr]};
        adcBit  = 0;
        spi_miso = adcWord[FB-1];
        capCnt = 0; capAddr = 0; edgeCnt = 0;
      end else if (!spi_cs_n) begin
        if (!prevSclk && spi_sclk) begin
          edgeCnt++;
          if (capCnt < AB) begin
            capAddr = capAddr * 2 + int'(spi_mosi);
            capCnt++;
          end
        end
        if (prevSclk && !spi_sclk) begin
          adcBit++;
          if (adcBit < FB) spi_miso = adcWord[FB-1-adcBit];
        end
      end else if (!prevCs && spi_cs_n) begin
        checkVal("sclkEdges", edgeCnt, FB);
        pendingAddr = capAddr;
        spi_miso = 1'b0;
      end
      prevCs   = spi_cs_n;
      prevSclk = spi_sclk;
      if (mActive) begin
        if (mPos == FrameLen - 1) begin
          if (enable && |channel_mask) begin
            mPos = 0; mDummy = 1'b0; mPrevAddr = mAddr;
            mAddr = nextCh(mAddr, channel_mask);
          end else begin
            mActive = 1'b0;
          end
        end else begin
          mPos++;
        end
      end else if (enable && |channel_mask) begin
        mActive = 1'b1; mPos = 0; mDummy = 1'b1; mPrevAddr = mAddr;
        mAddr = nextCh(NC - 1, channel_mask);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitPos(input int p);
    bit hit = 1'b0;
    for (int k = 0; k < 4 * FrameLen && !hit; k++) begin
      @(posedge clk); #1;
      if (mActive && mPos == p) hit = 1'b1;
    end
    checkVal("waitPos", hit, 1);
  endtask

  task automatic waitIdle();
    bit hit = 1'b0;
    for (int k = 0; k < 4 * FrameLen && !hit; k++) begin
      @(posedge clk); #1;
      if (!mActive) hit = 1'b1;
    end
    checkVal("waitIdle", hit, 1);
  endtask

  task automatic setAll(input logic [DB-1:0] v);
    for (int c = 0; c < NC; c++) chanVal[c] = v;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; channel_mask = '0;
    setAll('0);
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    // Idle with enable low.
    tick(100);
    checkVal("idleCs", spi_cs_n, 1);
    // Single channel.
    setAll(12'hA5C); channel_mask = 8'h01; enable = 1'b1;
    tick(5 * FrameLen + 4);
    checkVal("singleData", sample_data, 12'hA5C);
    // Round-robin over channels 0, 2, 7.
    for (int c = 0; c < NC; c++) chanVal[c] = DB'(12'h100 + c);
    channel_mask = 8'b1000_0101;
    tick(6 * FrameLen);
    // Extremes, with MISO high through the lead bits.
    leadOnes = 1'b1; setAll(12'h000);
    tick(3 * FrameLen);
    setAll(12'hFFF);
    tick(3 * FrameLen);
    leadOnes = 1'b0;
    // Drop enable mid-frame, then re-enable.
    waitPos(CD + 30);
    enable = 1'b0;
    waitIdle();
    tick(20);
    checkVal("abortBusy", busy, 0);
    enable = 1'b1;
    tick(3 * FrameLen);
    // Asynchronous reset mid-frame.
    waitPos(CD + 30);
    #2 rst = 1'b1;
    #1;
    checkVal("rstCs", spi_cs_n, 1);
    checkVal("rstSclk", spi_sclk, 0);
    checkVal("rstValid", sample_valid, 0);
    checkVal("rstData", sample_data, 0);
    tick(1);
    rst = 1'b0;
    tick(2 * FrameLen);
    // Empty mask, then mask cleared mid-scan.
    enable = 1'b0;
    waitIdle();
    channel_mask = '0; enable = 1'b1;
    tick(50);
    checkVal("emptyBusy", busy, 0);
    channel_mask = 8'h12;
    waitPos(40);
    channel_mask = '0;
    tick(2 * FrameLen);
    checkVal("maskZeroBusy", busy, 0);
    // Randomized mask/enable/data traffic.
    for (int it = 0; it < 25; it++) begin
      channel_mask = ($urandom_range(0, 3) == 0) ? '0 : NC'($urandom);
      enable       = ($urandom_range(0, 4) != 0);
      leadOnes     = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < NC; c++) chanVal[c] = DB'($urandom);
      tick($urandom_range(20, 300));
    end
    enable = 1'b0;
    waitIdle();
    tick(5);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/spi_adc_sequencer.md
# spi_adc_sequencer

Multi-channel SPI ADC controller that scans a configurable set of ADC input channels round-robin and delivers one tagged sample per conversion frame. It generates SPI mode-0 chip select, serial clock and the channel address on MOSI, and deserialises MISO. It sits between the external multiplexed SPI ADC (ADC128S022-class) and the sample-processing pipeline. It is the parametrised, multi-channel successor of the single-channel SPI read FSM.

## Interface
- NUM_CHANNELS, 8, ADC input channels; power of two, ≥2
- ADDR_BITS, $clog2(NUM_CHANNELS), width of channel address
- DATA_BITS, 12, conversion result bits, MSB first
- LEAD_BITS, 4, leading bits per frame (null/ignored); ADDR_BITS ≤ LEAD_BITS + DATA_BITS
- CLK_DIV, 2, clk cycles per SCLK half-period; ≥1
- CS_GAP, 2, clk cycles spi_cs_n held high between frames; ≥1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  scan enable
- channel_mask  in  NUM_CHANNELS  bit i=1 includes channel i in the scan
- spi_cs_n  out  1  ADC chip select, active-low
- spi_sclk  out  1  SPI clock, idle low
- spi_mosi  out  1  channel address to ADC
- spi_miso  in  1  ADC serial data
- sample_data  out  DATA_BITS  last conversion result
- sample_channel  out  ADDR_BITS  channel of sample_data
- sample_valid  out  1  one-cycle pulse: sample_data/sample_channel new
- busy  out  1  high in every state except IDLE

## Operation
- FRAME_BITS = LEAD_BITS + DATA_BITS. Bit period = 2·CLK_DIV clk cycles; phase p=0..2·CLK_DIV−1; spi_sclk=0 for p<CLK_DIV, 1 otherwise.
- States: IDLE, CS_SETUP, SHIFT, GAP.
  - IDLE: cs_n=1, sclk=0, mosi=0. Leaves to CS_SETUP when enable=1 and channel_mask≠0; that frame is marked dummy.
  - CS_SETUP: cs_n=0, sclk=0, exactly CLK_DIV cycles. On entry, next address = next set bit of channel_mask strictly after the current address, wrapping (first frame after IDLE: lowest set bit). Mask is sampled only here.
  - SHIFT: FRAME_BITS bit periods. mosi changes at p=0 of each bit: bits 0..ADDR_BITS−1 carry the address MSB first, rest 0. miso is registered on the clk edge where sclk rises (p=CLK_DIV−1→CLK_DIV). The first LEAD_BITS samples are discarded; the remaining DATA_BITS form the result, MSB first.
  - GAP: cs_n=1, sclk=0, mosi=0, CS_GAP cycles. Then CS_SETUP if enable=1 and channel_mask≠0, else IDLE.
- Address pipelining: the address sent in frame N selects the conversion returned in frame N+1. sample_channel = address of the previous frame. A dummy frame produces no sample_valid.
- Mask changes affect only the next CS_SETUP. Mask=0 at a frame boundary → IDLE.
- enable=0 mid-frame: the frame completes, including its sample_valid if it is not a dummy, then IDLE. Re-enable starts with a dummy frame.

## Timing
- Reset: cs_n=1, sclk=0, mosi=0, sample_data=0, sample_channel=0, sample_valid=0, busy=0, state IDLE. Reset mid-frame takes effect immediately (asynchronous). No partial sample is emitted.
- All outputs are registered; no combinational path from inputs to outputs.
- Frame length = CLK_DIV + 2·CLK_DIV·FRAME_BITS + CS_GAP clk cycles (defaults: 2+64+2 = 68).
- sample_valid pulses on the first GAP cycle; sample_data/sample_channel update in that cycle and hold until the next pulse.
- enable→first cs_n low: 1 cycle (IDLE→CS_SETUP registered).

## Test plan
- Reset/idle: hold enable=0 for 100 cycles after reset → all outputs at reset values, cs_n stays 1, no sclk edges.
- Single channel: mask=8'h01, enable=1, ADC model returns 0xA5C → frame 1 gives no valid. From frame 2: sample_valid every 68 cycles, data 0xA5C, channel 0, mosi address 000.
- Round-robin: mask=8'b1000_0101, model returns 0x100+ch → mosi addresses 0,2,7,0,2. Valids report (ch,data) (0,0x100),(2,0x102),(7,0x107),(0,0x100).
- Lead bits/extremes: miso=1 during lead bits and data 0x000 → sample_data 0x000. Data 0xFFF → 0xFFF. Exactly 16 rising sclk edges per frame.
- Abort: enable→0 at cycle 30 of SHIFT → frame finishes, one sample_valid, then cs_n=1 and busy=0. Re-enable → the next frame is a dummy. Reset at cycle 30 of SHIFT → cs_n=1 and sclk=0 immediately, no sample_valid.
- Empty mask: enable=1 with mask=0 → stays IDLE, busy=0. Mask→0 mid-scan → current frame completes, then IDLE.
